// File: rtl/sseg_scan_ctrl.sv
// Round-robin seven-segment scan scheduler: guard-blank step, 15 PWM steps per digit,
// and frame-boundary shadow updates through a load/ready handshake.
module sseg_scan_ctrl #(
  parameter int DIGITS      = 8,
  parameter int STEP_CYCLES = 6250,
  parameter int STEP_W      = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en_in,
  input  logic [3:0]            bright_in,
  output logic                  ready,
  output logic [3:0]            num,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [STEP_W-1:0] PRESC_MAX = STEP_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  logic [1:0]          state, nxt_state;
  logic [IDX_W-1:0]    idx, nxt_idx;
  logic [3:0]          step, nxt_step;
  logic [STEP_W-1:0]   presc, nxt_presc;

  logic [4*DIGITS-1:0] stg_data, shd_data, nxt_shd_data;
  logic [DIGITS-1:0]   stg_dp, shd_dp, nxt_shd_dp;
  logic [DIGITS-1:0]   stg_en, shd_en, nxt_shd_en;
  logic [3:0]          stg_bright, shd_bright, nxt_shd_bright;
  logic                pending, nxt_pending;

  logic                step_end, slot_end, frame_end, start, apply;
  logic [DIGITS-1:0]   an_nxt;

  assign step_end  = (presc == PRESC_MAX);
  assign slot_end  = (state == ST_DRIVE) && step_end && (step == 4'd15);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign start     = (state == ST_IDLE) && enable;
  assign apply     = (frame_end || start) && pending;

  // A load on the applying edge refills staging and keeps the request pending.
  assign nxt_pending    = load | (pending & ~apply);
  assign nxt_shd_data   = apply ? stg_data   : shd_data;
  assign nxt_shd_dp     = apply ? stg_dp     : shd_dp;
  assign nxt_shd_en     = apply ? stg_en     : shd_en;
  assign nxt_shd_bright = apply ? stg_bright : shd_bright;

  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_step  = step;
    nxt_presc = presc;
    case (state)
      ST_IDLE: begin
        nxt_presc = '0;
        nxt_step  = 4'd0;
        nxt_idx   = '0;
        if (enable) nxt_state = ST_BLANK;
      end
      ST_BLANK: begin
        if (step_end) begin
          nxt_presc = '0;
          nxt_step  = 4'd1;
          nxt_state = ST_DRIVE;
        end else begin
          nxt_presc = presc + 1'b1;
        end
      end
      ST_DRIVE: begin
        if (step_end) begin
          nxt_presc = '0;
          if (step == 4'd15) begin
            nxt_step = 4'd0;
            if (enable) begin
              nxt_state = ST_BLANK;
              nxt_idx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
              nxt_state = ST_IDLE;
              nxt_idx   = '0;
            end
          end else begin
            nxt_step = step + 4'd1;
          end
        end else begin
          nxt_presc = presc + 1'b1;
        end
      end
      default: begin
        nxt_state = ST_IDLE;
        nxt_idx   = '0;
        nxt_step  = 4'd0;
        nxt_presc = '0;
      end
    endcase
  end

  // Outputs are decoded from next-state values so they move on the same edge as step/digit.
  always_comb begin
    an_nxt = '1;
    if ((nxt_state == ST_DRIVE) && nxt_shd_en[nxt_idx] && (nxt_step <= nxt_shd_bright))
      an_nxt[nxt_idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      step       <= 4'd0;
      presc      <= '0;
      stg_data   <= '0;
      stg_dp     <= '0;
      stg_en     <= '0;
      stg_bright <= 4'd0;
      shd_data   <= '0;
      shd_dp     <= '0;
      shd_en     <= '0;
      shd_bright <= 4'd0;
      pending    <= 1'b0;
      ready      <= 1'b1;
      an         <= '1;
      num        <= 4'd0;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= nxt_state;
      idx        <= nxt_idx;
      step       <= nxt_step;
      presc      <= nxt_presc;
      if (load) begin
        stg_data   <= data_in;
        stg_dp     <= dp_in;
        stg_en     <= digit_en_in;
        stg_bright <= bright_in;
      end
      shd_data   <= nxt_shd_data;
      shd_dp     <= nxt_shd_dp;
      shd_en     <= nxt_shd_en;
      shd_bright <= nxt_shd_bright;
      pending    <= nxt_pending;
      ready      <= ~nxt_pending;
      an         <= an_nxt;
      num        <= nxt_shd_data[{nxt_idx, 2'b00} +: 4];
      dp_n       <= ~nxt_shd_dp[nxt_idx];
      frame_done <= frame_end;
    end
  end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
- Time-multiplexing scheduler that shares one seven-segment decoder (sseg_driver) and its cathode bus between DIGITS anode-selected digits.
- Sequences the digits round-robin with a guard-blank step between digits and a 4-bit PWM brightness.
- Takes display updates through a load/ready handshake and applies them only at frame boundaries, so a frame never shows a torn mix of old and new data.
- Sits between the counters that produce display values and sseg_driver/AN on the board top.

Parameters:
- DIGITS, 8, number of multiplexed digits (2..8).
- STEP_CYCLES, 6250, clk cycles per PWM step. 16 steps per digit slot give a 125 Hz frame at 100 MHz with 8 digits.
- STEP_W, 13, width of the step prescaler; must hold STEP_CYCLES-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  scanning enable. When low, the display goes dark at the next slot boundary.
- load  in  1  one-cycle request to capture the staging inputs below.
- data_in  in  4*DIGITS  nibble per digit; digit k is data_in[4k+3:4k].
- dp_in  in  DIGITS  decimal point per digit, 1 = lit.
- digit_en_in  in  DIGITS  per-digit enable; a disabled digit keeps its slot but its anode stays off.
- bright_in  in  4  brightness, 0 = dark, 15 = maximum.
- ready  out  1  high when no update is pending.
- num  out  4  nibble to sseg_driver for the current slot.
- dp_n  out  1  active-low decimal point.
- an  out  DIGITS  active-low anodes; at most one bit low.
- frame_done  out  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset values: an all ones, num 0, dp_n 1, frame_done 0, ready 1, FSM in IDLE, digit index 0, step 0, prescaler 0. Staging and shadow registers are 0, so the display is dark until the first load is applied.
- Handshake:
  - load=1 copies data_in, dp_in, digit_en_in and bright_in into staging registers and sets pending; ready = !pending, registered.
  - load while pending overwrites staging (last load wins); pending stays set.
  - At a frame boundary with pending=1, staging is copied to shadow and pending clears on the same edge.
  - load on that same edge is captured into staging and pending stays 1, so that update lands at the next boundary.
- Frame boundary: the edge where digit DIGITS-1, step 15, prescaler STEP_CYCLES-1 completes, or the IDLE->BLANK transition.
- Timing: the prescaler counts 0..STEP_CYCLES-1; its wrap advances step 0..15; the step-15 wrap advances the digit index 0..DIGITS-1, then wraps to 0.
- FSM states:
  - IDLE: an all ones, prescaler held at 0. Moves to BLANK at digit 0 when enable=1; the shadow update happens on this edge.
  - BLANK: step 0. an all ones, num/dp_n already show the current digit. Moves to DRIVE after STEP_CYCLES cycles.
  - DRIVE: steps 1..15. an[idx]=0 only if shadow digit_en[idx]=1 and step <= shadow brightness; otherwise all ones. At the end of step 15 it goes to BLANK of the next digit if enable=1, else to IDLE with index reset to 0.
- Outputs are registered. an, num and dp_n change on the same edge the step or digit changes.
  - num = shadow nibble[idx].
  - dp_n = ~shadow dp[idx].
- frame_done pulses on the cycle after the frame boundary edge. It does not pulse for IDLE->BLANK.
- enable deasserted mid-slot: the current slot completes unchanged, then IDLE.
- reset mid-frame: all state returns to reset values on the next edge; pending and staging clear.
- Brightness 0 gives a dark display with scanning and frame_done still running. Brightness 15 lights steps 1..15, a 15/16 duty.

Test Plan (DIGITS=4, STEP_CYCLES=2: slot 32 cycles, frame 128):
- Reset, then load with data_in=16'h4321, dp_in=4'b0010, digit_en_in=4'hF, bright_in=15, enable=1 -> ready falls for 1 cycle then rises. The first 2 cycles of each slot have an=4'hF. Then an=4'b1110 with num=1 for 30 cycles, then num=2 with dp_n=0 on digit 1, and so on. frame_done pulses every 128 cycles.
- bright_in=3 -> per slot: 2 cycles dark, 6 cycles an[idx] low, 24 cycles dark. bright_in=0 -> an stays 4'hF while frame_done keeps pulsing.
- digit_en_in=4'b0101 -> an is never low for digits 1 and 3, while their slot timing is unchanged and num still cycles 1,2,3,4.
- Load 16'hAAAA mid-frame, then 16'hBBBB before the boundary -> ready stays 0 until the boundary. No A ever appears; the next frame shows B on all digits, ready returns to 1, and the current frame completes with the old value.
- Drop enable during digit 2, step 5 -> digit 2 finishes step 15, then an=4'hF and idle. Re-raise enable -> restarts at digit 0, step 0 (blank), with no frame_done for the restart.
- Assert reset during DRIVE with a load pending -> the next cycle shows an=4'hF, num=0, dp_n=1, ready=1, and with enable held high the block restarts dark because the shadow is cleared.
